// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/WAIT request FSM, one outstanding request,
// 2-entry in-order response buffer toward decode, redirect with response discard.
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets
// (sticky addr_err_o, requests stop). Without it redirect_pc_i[1:0] is forced to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_fetch_o,
  output logic [31:0] pc_fetch_o,
  output logic        valid_fetch_o,
  output logic        addr_err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_pc_q;       // address of the outstanding request
  logic        discard_q;      // drop the next response (stale after redirect)
  logic        err_q;
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_instr_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;

  logic [31:0] redirect_tgt;
  logic        redirect_bad;
  logic        req;
  logic        xfer;
  logic        resp;
  logic        push;
  logic        pop;

  // Condition the redirect target according to the alignment option
  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    redirect_tgt = redirect_pc_i;
    redirect_bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
`else
    redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    redirect_bad = 1'b0;
`endif
  end

  // Request gating and buffer push/pop decisions
  always_comb begin
    // Outstanding count is zero whenever we are in StReq, so only occupancy matters here
    req  = (state_q == StReq) && (count_q != 2'd2) && !err_q;
    xfer = req & imem_gnt_i;
    resp = (state_q == StWait) & imem_rvalid_i;
    push = resp & !discard_q & !redirect_i;
    pop  = (count_q != 2'd0) & !stall_i & !redirect_i;
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign valid_fetch_o = (count_q != 2'd0);
  assign instr_fetch_o = buf_instr_q[rd_ptr_q];
  assign pc_fetch_o    = buf_pc_q[rd_ptr_q];
`ifdef FETCH_ALIGN_CHECK_EN
  assign addr_err_o    = err_q;
`else
  assign addr_err_o    = 1'b0;
`endif

  // FSM, fetch PC, discard flag and response buffer state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]    <= 32'd0;
        buf_instr_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (xfer) begin
            state_q    <= StWait;
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        StWait: begin
          if (imem_rvalid_i) state_q <= StReq;
        end
        default: state_q <= StIdle;
      endcase

      // A response arriving together with the redirect is dropped right away,
      // so the flag is only needed when the response is still to come.
      if (redirect_i && (((state_q == StWait) && !imem_rvalid_i) || xfer)) begin
        discard_q <= 1'b1;
      end else if (resp) begin
        discard_q <= 1'b0;
      end

      if (redirect_i) begin
        fetch_pc_q <= redirect_tgt;   // overrides the +4 of a coinciding grant
        count_q    <= 2'd0;
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        if (redirect_bad) err_q <= 1'b1;
      end else begin
        if (push) begin
          buf_pc_q[wr_ptr_q]    <= req_pc_q;
          buf_instr_q[wr_ptr_q] <= imem_rdata_i;
          wr_ptr_q              <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, fetch-PC model and an
// in-order scoreboard of expected {pc, instr} pairs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_fetch_o;
  logic [31:0] pc_fetch_o;
  logic        valid_fetch_o;
  logic        addr_err_o;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_fetch_o(instr_fetch_o),
    .pc_fetch_o   (pc_fetch_o),
    .valid_fetch_o(valid_fetch_o),
    .addr_err_o   (addr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int mism   = 0;

  logic [63:0] sb[$];        // expected {pc, instr} in delivery order
  logic [31:0] pop_log[$];   // pcs actually consumed from the DUT

  logic [31:0] exp_pc;
  logic [31:0] infl_addr;
  logic [31:0] infl_dut_addr;
  logic        inflight;
  logic        infl_drop;
  logic        rsp_sent;
  logic        stray;
  logic        model_on;
  int          rsp_cnt;
  int          rsp_lo;
  int          rsp_hi;

  logic        s_req;
  logic        s_valid;
  logic        s_err;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    sb.delete();
    inflight      = 1'b0;
    infl_drop     = 1'b0;
    rsp_sent      = 1'b0;
    stray         = 1'b0;
    exp_pc        = RESET_PC;
    imem_rvalid_i = 1'b0;
  endtask

  // One clock cycle: sample and check at negedge, update model, respond after posedge
  task automatic tick();
    @(negedge clk);
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = valid_fetch_o;
    s_pc    = pc_fetch_o;
    s_instr = instr_fetch_o;
    s_err   = addr_err_o;
    if (rst_n && model_on) begin
      checks++;
      if (s_valid !== (sb.size() != 0)) begin
        mism++;
        $display("FAIL valid_fetch: got %b want %b", s_valid, sb.size() != 0);
      end
      if (s_valid && sb.size() != 0) begin
        checks++;
        if ({s_pc, s_instr} !== sb[0]) begin
          mism++;
          $display("FAIL head_entry: got pc=%h instr=%h want pc=%h instr=%h",
                   s_pc, s_instr, sb[0][63:32], sb[0][31:0]);
        end
      end
      if (sb.size() + int'(inflight) >= 2) begin
        checks++;
        if (s_req !== 1'b0) begin
          mism++;
          $display("FAIL req_backpressure: got req=%b want 0 (occ=%0d outst=%0d)",
                   s_req, sb.size(), inflight);
        end
      end
      if (s_req) begin
        checks++;
        if (s_addr !== exp_pc) begin
          mism++;
          $display("FAIL imem_addr: got %h want %h", s_addr, exp_pc);
        end
      end
      if (s_valid && !stall && !redirect) begin
        pop_log.push_back(s_pc);
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (imem_rvalid_i && inflight) begin
        if (!infl_drop && !redirect) sb.push_back({infl_addr, mem(infl_addr)});
        inflight = 1'b0;
      end
      if (s_req && imem_gnt_i) begin
        inflight      = 1'b1;
        rsp_sent      = 1'b0;
        infl_drop     = redirect;
        infl_addr     = exp_pc;
        infl_dut_addr = s_addr;
        exp_pc        = exp_pc + 32'd4;
        rsp_cnt       = int'($urandom_range(rsp_hi, rsp_lo));
      end
      if (redirect) begin
        sb.delete();
        if (inflight) infl_drop = 1'b1;
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      stray         = 1'b0;
    end else if (inflight && !rsp_sent) begin
      if (rsp_cnt <= 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem(infl_dut_addr);
        rsp_sent      = 1'b1;
      end else begin
        rsp_cnt--;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  // Wait (bounded) until at least n pops were logged
  task automatic wait_pops(input int n, input string name);
    for (int i = 0; i < 60 && pop_log.size() < n; i++) tick();
    if (pop_log.size() < n) begin
      checks++;
      mism++;
      $display("FAIL %s_timeout: got %0d pops want %0d", name, pop_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks += 6;
    if (imem_req_o !== 1'b0) begin mism++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    if (valid_fetch_o !== 1'b0) begin mism++; $display("FAIL rst_valid: got %b want 0", valid_fetch_o); end
    if (addr_err_o !== 1'b0) begin mism++; $display("FAIL rst_err: got %b want 0", addr_err_o); end
    if (instr_fetch_o !== 32'd0) begin mism++; $display("FAIL rst_instr: got %h want 0", instr_fetch_o); end
    if (pc_fetch_o !== 32'd0) begin mism++; $display("FAIL rst_pc: got %h want 0", pc_fetch_o); end
    if (imem_addr_o !== RESET_PC) begin mism++; $display("FAIL rst_addr: got %h want %h", imem_addr_o, RESET_PC); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    imem_gnt_i = 1'b1;
    stall      = 1'b0;
    rsp_lo = 1; rsp_hi = 1;
    pop_log.delete();
    tick();
    checks++;
    if (s_req !== 1'b0) begin mism++; $display("FAIL idle_req: got %b want 0", s_req); end
    tick();
    checks++;
    if (s_req !== 1'b1) begin mism++; $display("FAIL first_req: got %b want 1", s_req); end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin mism++; $display("FAIL early_valid: got %b want 0", s_valid); end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== RESET_PC) begin
      mism++;
      $display("FAIL first_valid: got valid=%b pc=%h want 1 %h", s_valid, s_pc, RESET_PC);
    end
    wait_pops(3, "stream");
    if (pop_log.size() >= 3) begin
      checks++;
      if (pop_log[0] !== 32'hBFC0_0000 || pop_log[1] !== 32'hBFC0_0004 ||
          pop_log[2] !== 32'hBFC0_0008) begin
        mism++;
        $display("FAIL stream_seq: got %h %h %h want bfc00000 bfc00004 bfc00008",
                 pop_log[0], pop_log[1], pop_log[2]);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    repeat (6) tick();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      mism++;
      $display("FAIL stall_full: got req=%b valid=%b want req=0 valid=1", s_req, s_valid);
    end
    stall = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_redirect_wait();
    rsp_lo = 3; rsp_hi = 3;
    imem_gnt_i = 1'b1;
    for (int i = 0; i < 20 && !inflight; i++) tick();
    checks++;
    if (!inflight) begin mism++; $display("FAIL rdw_grant_timeout: got no grant want grant"); end
    pop_log.delete();
    do_redirect(32'h0000_0100);
    rsp_lo = 1; rsp_hi = 1;
    wait_pops(1, "rdw");
    if (pop_log.size() >= 1) begin
      checks++;
      if (pop_log[0] !== 32'h0000_0100) begin
        mism++;
        $display("FAIL rdw_pc: got %h want 00000100", pop_log[0]);
      end
    end
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a0;
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_req) break;
    end
    a0 = s_addr;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== a0) begin
      mism++;
      $display("FAIL hold_addr: got req=%b addr=%h want 1 %h", s_req, s_addr, a0);
    end
    do_redirect(32'h0000_2000);
    checks++;
    if (s_addr !== a0) begin mism++; $display("FAIL hold_addr_rd: got %h want %h", s_addr, a0); end
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_2000) begin
      mism++;
      $display("FAIL hold_new_addr: got req=%b addr=%h want 1 00002000", s_req, s_addr);
    end
    tick();
    imem_gnt_i = 1'b1;
    pop_log.delete();
    wait_pops(1, "hold");
    if (pop_log.size() >= 1) begin
      checks++;
      if (pop_log[0] !== 32'h0000_2000) begin
        mism++;
        $display("FAIL hold_pc: got %h want 00002000", pop_log[0]);
      end
    end
  endtask

  task automatic test_wrap();
    imem_gnt_i = 1'b1;
    pop_log.delete();
    do_redirect(32'hFFFF_FFFC);
    wait_pops(2, "wrap");
    if (pop_log.size() >= 2) begin
      checks++;
      if (pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0000_0000) begin
        mism++;
        $display("FAIL wrap_seq: got %h %h want fffffffc 00000000", pop_log[0], pop_log[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    rsp_lo = 2; rsp_hi = 2;
    for (int i = 0; i < 20 && !inflight; i++) tick();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (valid_fetch_o !== 1'b0 || imem_req_o !== 1'b0) begin
      mism++;
      $display("FAIL mid_rst_out: got valid=%b req=%b want 0 0", valid_fetch_o, imem_req_o);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    imem_gnt_i = 1'b0;
    rsp_lo = 1; rsp_hi = 1;
    stray = 1'b1;
    repeat (4) tick();
    checks++;
    if (s_valid !== 1'b0) begin mism++; $display("FAIL stray_rsp: got valid=%b want 0", s_valid); end
    imem_gnt_i = 1'b1;
    pop_log.delete();
    wait_pops(1, "mid_rst");
    if (pop_log.size() >= 1) begin
      checks++;
      if (pop_log[0] !== RESET_PC) begin
        mism++;
        $display("FAIL mid_rst_pc: got %h want %h", pop_log[0], RESET_PC);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_lo = 1; rsp_hi = 3;
    for (int i = 0; i < 300; i++) begin
      imem_gnt_i = ($urandom_range(3, 0) != 0);
      stall      = ($urandom_range(3, 0) == 0);
      if ($urandom_range(19, 0) == 0) do_redirect($urandom() & 32'hFFFF_FFFC);
      else tick();
    end
    stall      = 1'b0;
    imem_gnt_i = 1'b1;
    repeat (10) tick();
    checks++;
    if (s_err !== 1'b0) begin mism++; $display("FAIL err_aligned: got %b want 0", s_err); end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    imem_gnt_i = 1'b1;
    model_on   = 1'b0;
    do_redirect(32'h0000_0102);
    checks++;
    if (s_err !== 1'b0) begin mism++; $display("FAIL align_pre: got %b want 0", s_err); end
    tick();
    checks++;
    if (s_err !== 1'b1) begin mism++; $display("FAIL align_err: got %b want 1", s_err); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_req !== 1'b0 || s_err !== 1'b1) begin
        mism++;
        $display("FAIL align_stop: got req=%b err=%b want 0 1", s_req, s_err);
      end
    end
  endtask
`endif

  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'd0;
    model_on      = 1'b1;
    rsp_lo        = 1;
    rsp_hi        = 1;
    rsp_cnt       = 0;
    infl_addr     = 32'd0;
    infl_dut_addr = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_gnt_hold();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, mism);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
